// File: rtl/ram_mov_moc_param.sv
// Byte-addressed big-endian data memory with MOV/MOC handshake.
// Ports: Clk, Reset (sync, high), MOV/ReadWrite/Address/DataIn/
// DataType/Signed requests; DataOut, MOC, Fault responses.
module ram_mov_moc_param #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  MOV,
  input  logic                  ReadWrite,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [31:0]           DataIn,
  input  logic [1:0]            DataType,
  input  logic                  Signed,
  output logic [31:0]           DataOut,
  output logic                  MOC,
  output logic                  Fault
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  logic [7:0] Mem [0:2**ADDR_WIDTH-1];

  state_t                state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  rw_q;
  logic [31:0]           din_q;
  logic [1:0]            type_q;
  logic                  sgn_q;

  logic [ADDR_WIDTH-1:0] a1;
  logic [ADDR_WIDTH-1:0] a2;
  logic [ADDR_WIDTH-1:0] a3;
  logic [7:0]            b0;
  logic [7:0]            b1;
  logic [7:0]            b2;
  logic [7:0]            b3;
  logic                  is_byte;
  logic                  is_half;
  logic                  is_word;
  logic                  bad;
  logic                  ext;
  logic [31:0]           rdata;
  logic                  fire;
  logic                  we;

  assign a1 = addr_q + ADDR_WIDTH'(1);
  assign a2 = addr_q + ADDR_WIDTH'(2);
  assign a3 = addr_q + ADDR_WIDTH'(3);

  assign b0 = Mem[addr_q];
  assign b1 = Mem[a1];
  assign b2 = Mem[a2];
  assign b3 = Mem[a3];

  assign is_byte = (type_q == 2'b00);
  assign is_half = (type_q == 2'b01);
  assign is_word = (type_q == 2'b10);

  assign bad = (type_q == 2'b11)
             | (is_half & addr_q[0])
             | (is_word & (addr_q[1:0] != 2'b00));

  // sign bit is the MSB of the first (most significant) byte loaded
  assign ext = sgn_q & b0[7];

  always_comb begin
    rdata = {b0, b1, b2, b3};
    unique case (1'b1)
      is_byte: rdata = {{24{ext}}, b0};
      is_half: rdata = {{16{ext}}, b0, b1};
      default: rdata = {b0, b1, b2, b3};
    endcase
  end

  // completion edge: counter exhausted and master still requesting
  assign fire = (state == BUSY) & MOV & (cnt == 4'd0) & ~Reset;
  assign we   = fire & ~rw_q & ~bad;

  always_ff @(posedge Clk) begin
    if (we) begin
      unique case (1'b1)
        is_byte: Mem[addr_q] <= din_q[7:0];
        is_half: begin
          Mem[addr_q] <= din_q[15:8];
          Mem[a1]     <= din_q[7:0];
        end
        default: begin
          Mem[addr_q] <= din_q[31:24];
          Mem[a1]     <= din_q[23:16];
          Mem[a2]     <= din_q[15:8];
          Mem[a3]     <= din_q[7:0];
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      MOC     <= 1'b0;
      Fault   <= 1'b0;
      DataOut <= 32'd0;
      addr_q  <= '0;
      rw_q    <= 1'b1;
      din_q   <= 32'd0;
      type_q  <= 2'b00;
      sgn_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (MOV) begin
            addr_q <= Address;
            rw_q   <= ReadWrite;
            din_q  <= DataIn;
            type_q <= DataType;
            sgn_q  <= Signed;
            cnt    <= 4'(LATENCY);
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (!MOV) begin
            state <= IDLE;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            MOC   <= 1'b1;
            Fault <= bad;
            if (bad || !rw_q) begin
              DataOut <= 32'd0;
            end else begin
              DataOut <= rdata;
            end
            state <= DONE;
          end
        end
        DONE: begin
          if (!MOV) begin
            MOC   <= 1'b0;
            Fault <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_mov_moc_param.sv
// Directed bench for ram_mov_moc_param: LATENCY=2 and LATENCY=0
// instances, table of transfers plus abort/reset sequences.
module tb_ram_mov_moc_param;

  logic        clk;
  logic        rst;
  logic        mov  [2];
  logic        rw   [2];
  logic [7:0]  addr [2];
  logic [31:0] din  [2];
  logic [1:0]  dt   [2];
  logic        sg   [2];
  logic [31:0] dout [2];
  logic        moc  [2];
  logic        flt  [2];

  int n_chk;
  int n_err;

  ram_mov_moc_param #(.ADDR_WIDTH(8), .LATENCY(2)) u0 (
    .Clk(clk), .Reset(rst), .MOV(mov[0]), .ReadWrite(rw[0]),
    .Address(addr[0]), .DataIn(din[0]), .DataType(dt[0]),
    .Signed(sg[0]), .DataOut(dout[0]), .MOC(moc[0]),
    .Fault(flt[0])
  );

  ram_mov_moc_param #(.ADDR_WIDTH(8), .LATENCY(0)) u1 (
    .Clk(clk), .Reset(rst), .MOV(mov[1]), .ReadWrite(rw[1]),
    .Address(addr[1]), .DataIn(din[1]), .DataType(dt[1]),
    .Signed(sg[1]), .DataOut(dout[1]), .MOC(moc[1]),
    .Fault(flt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          s;
    logic        r;
    logic [7:0]  a;
    logic [31:0] d;
    logic [1:0]  t;
    logic        sg;
    logic [31:0] eo;
    logic        ef;
    int          el;
    string       nm;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int s, logic r, logic [7:0] a,
                              logic [31:0] d, logic [1:0] t,
                              logic sgn, logic [31:0] eo,
                              logic ef, string nm);
    vec_t v;
    v.s  = s;
    v.r  = r;
    v.a  = a;
    v.d  = d;
    v.t  = t;
    v.sg = sgn;
    v.eo = eo;
    v.ef = ef;
    v.el = (s == 0) ? 3 : 1;
    v.nm = nm;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // one full handshake; lat = edges after the accepting edge
  task automatic do_req(input int s, input logic r,
                        input logic [7:0] a, input logic [31:0] d,
                        input logic [1:0] t, input logic sgn,
                        output logic [31:0] o, output logic f,
                        output int lat, output logic drop);
    int e;
    @(negedge clk);
    rw[s]   = r;
    addr[s] = a;
    din[s]  = d;
    dt[s]   = t;
    sg[s]   = sgn;
    mov[s]  = 1'b1;
    e = 0;
    do begin
      @(posedge clk);
      #1;
      e++;
    end while (!moc[s] && e < 40);
    lat = e - 1;
    o   = dout[s];
    f   = flt[s];
    @(negedge clk);
    mov[s] = 1'b0;
    @(posedge clk);
    #1;
    drop = moc[s] | flt[s];
    @(negedge clk);
  endtask

  logic [31:0] o;
  logic        f;
  logic        drop;
  int          lat;
  int          e;

  initial begin
    n_chk = 0;
    n_err = 0;
    rst   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mov[i]  = 1'b0;
      rw[i]   = 1'b1;
      addr[i] = 8'h00;
      din[i]  = 32'h0;
      dt[i]   = 2'b10;
      sg[i]   = 1'b0;
    end

    for (int i = 0; i < 256; i++) begin
      u0.Mem[i] = 8'h00;
      u1.Mem[i] = 8'h00;
    end
    u0.Mem[0]   = 8'h12; u0.Mem[1]   = 8'h34;
    u0.Mem[2]   = 8'h56; u0.Mem[3]   = 8'h78;
    u0.Mem[4]   = 8'hF0; u0.Mem[5]   = 8'h9A;
    u0.Mem[6]   = 8'h11; u0.Mem[7]   = 8'h22;
    u0.Mem[8]   = 8'hA1; u0.Mem[9]   = 8'hA2;
    u0.Mem[10]  = 8'hA3; u0.Mem[11]  = 8'hA4;
    u0.Mem[12]  = 8'hC1; u0.Mem[13]  = 8'hC2;
    u0.Mem[14]  = 8'hC3; u0.Mem[15]  = 8'hC4;
    u0.Mem[254] = 8'h80; u0.Mem[255] = 8'h01;
    u1.Mem[0]   = 8'h01; u1.Mem[1]   = 8'h02;
    u1.Mem[2]   = 8'h03; u1.Mem[3]   = 8'h04;

    vecs.push_back(mk(0, 1, 8'd0,  0, 2'b10, 0, 32'h12345678, 0, "w_rd_a0"));
    vecs.push_back(mk(0, 1, 8'd2,  0, 2'b00, 0, 32'h00000056, 0, "b_rd_a2"));
    vecs.push_back(mk(0, 1, 8'd4,  0, 2'b00, 1, 32'hFFFFFFF0, 0, "b_rds_a4"));
    vecs.push_back(mk(0, 1, 8'd2,  0, 2'b01, 0, 32'h00005678, 0, "h_rd_a2"));
    vecs.push_back(mk(0, 0, 8'd6,  32'hAAAABEEF, 2'b01, 0, 0, 0, "h_wr_a6"));
    vecs.push_back(mk(0, 1, 8'd4,  0, 2'b10, 0, 32'hF09ABEEF, 0, "w_rd_a4"));
    vecs.push_back(mk(0, 1, 8'd1,  0, 2'b10, 0, 32'h0, 1, "w_mis_a1"));
    vecs.push_back(mk(0, 0, 8'd8,  32'hDEADBEEF, 2'b11, 0, 0, 1, "ill_wr_a8"));
    vecs.push_back(mk(0, 1, 8'd8,  0, 2'b10, 0, 32'hA1A2A3A4, 0, "w_rd_a8"));
    vecs.push_back(mk(0, 1, 8'd0,  0, 2'b01, 1, 32'h00001234, 0, "h_rds_a0"));
    vecs.push_back(mk(0, 1, 8'd4,  0, 2'b01, 1, 32'hFFFFF09A, 0, "h_rds_a4"));
    vecs.push_back(mk(0, 0, 8'd9,  32'h12345655, 2'b00, 0, 0, 0, "b_wr_a9"));
    vecs.push_back(mk(0, 1, 8'd8,  0, 2'b10, 0, 32'hA155A3A4, 0, "w_rd_a8b"));
    vecs.push_back(mk(0, 0, 8'd16, 32'hCAFEF00D, 2'b10, 0, 0, 0, "w_wr_a16"));
    vecs.push_back(mk(0, 1, 8'd16, 0, 2'b10, 1, 32'hCAFEF00D, 0, "w_rd_a16"));
    vecs.push_back(mk(0, 1, 8'd17, 0, 2'b01, 0, 32'h0, 1, "h_mis_a17"));
    vecs.push_back(mk(0, 1, 8'd17, 0, 2'b00, 1, 32'hFFFFFFFE, 0, "b_rds_a17"));
    vecs.push_back(mk(0, 1, 8'hFE, 0, 2'b01, 1, 32'hFFFF8001, 0, "h_rds_top"));
    vecs.push_back(mk(0, 0, 8'hFF, 32'h000000C3, 2'b00, 0, 0, 0, "b_wr_top"));
    vecs.push_back(mk(0, 1, 8'hFC, 0, 2'b10, 0, 32'h000080C3, 0, "w_rd_top"));
    vecs.push_back(mk(1, 1, 8'd0,  0, 2'b10, 0, 32'h01020304, 0, "l0_rd"));
    vecs.push_back(mk(1, 0, 8'd0,  32'h89ABCDEF, 2'b10, 0, 0, 0, "l0_wr"));
    vecs.push_back(mk(1, 1, 8'd0,  0, 2'b10, 0, 32'h89ABCDEF, 0, "l0_rd2"));
    vecs.push_back(mk(1, 1, 8'd1,  0, 2'b00, 0, 32'h000000AB, 0, "l0_b_rd"));

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_moc", 32'(moc[i]), 32'h0);
      chk("rst_dout", dout[i], 32'h0);
      chk("rst_fault", 32'(flt[i]), 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      do_req(vecs[i].s, vecs[i].r, vecs[i].a, vecs[i].d,
             vecs[i].t, vecs[i].sg, o, f, lat, drop);
      chk({vecs[i].nm, "_dout"}, o, vecs[i].eo);
      chk({vecs[i].nm, "_fault"}, 32'(f), 32'(vecs[i].ef));
      chk({vecs[i].nm, "_lat"}, 32'(lat), 32'(vecs[i].el));
      chk({vecs[i].nm, "_drop"}, 32'(drop), 32'h0);
    end

    // abort: drop MOV while BUSY on a word write to A=12
    @(negedge clk);
    rw[0]   = 1'b0;
    addr[0] = 8'd12;
    din[0]  = 32'h11223344;
    dt[0]   = 2'b10;
    mov[0]  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mov[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("abort_moc", 32'(moc[0]), 32'h0);
    end
    @(negedge clk);
    do_req(0, 1, 8'd12, 0, 2'b10, 0, o, f, lat, drop);
    chk("abort_mem", o, 32'hC1C2C3C4);

    // latched request: inputs changed in BUSY are ignored,
    // then Reset while in DONE clears outputs
    @(negedge clk);
    rw[0]   = 1'b1;
    addr[0] = 8'd0;
    dt[0]   = 2'b10;
    sg[0]   = 1'b0;
    mov[0]  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    addr[0] = 8'd4;
    dt[0]   = 2'b00;
    rw[0]   = 1'b0;
    e = 0;
    do begin
      @(posedge clk);
      #1;
      e++;
    end while (!moc[0] && e < 40);
    chk("latch_moc", 32'(moc[0]), 32'h1);
    chk("latch_dout", dout[0], 32'h12345678);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstd_moc", 32'(moc[0]), 32'h0);
    chk("rstd_dout", dout[0], 32'h0);
    chk("rstd_fault", 32'(flt[0]), 32'h0);
    @(negedge clk);
    rst    = 1'b0;
    mov[0] = 1'b0;
    @(negedge clk);
    do_req(0, 1, 8'd4, 0, 2'b10, 0, o, f, lat, drop);
    chk("after_rst_rd", o, 32'hF09ABEEF);
    chk("after_rst_lat", 32'(lat), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ram_mov_moc_param.md
Name: ram_mov_moc_param

Overview:
- Parametrised, byte-addressed, big-endian data memory with the MOV/MOC request/acknowledge handshake, successor to ram256x32.
- Adds configurable address width and access latency, clocked operation, signed/unsigned sub-word loads, and an alignment/illegal-type fault indication.
- Sits between the CPU memory-interface state machine and storage.
- Testbenches preload it hierarchically through the byte array Mem.

Parameters:
ADDR_WIDTH, 8, byte-address width; Mem holds 2**ADDR_WIDTH bytes
LATENCY, 2, wait cycles between request acceptance and MOC assertion (0..15)

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  synchronous, active-high
MOV  input  1  memory operation valid (request), level-held by master
ReadWrite  input  1  1 = read, 0 = write
Address  input  ADDR_WIDTH  byte address
DataIn  input  32  write data, right-justified for byte/halfword
DataType  input  2  00 byte, 01 halfword, 10 word, 11 illegal
Signed  input  1  sign-extend byte/halfword reads when 1
DataOut  output  32  read data, right-justified
MOC  output  1  memory operation complete (acknowledge)
Fault  output  1  misaligned or illegal access; valid while MOC=1

Behaviour:
- Storage: reg [7:0] Mem[0:2**ADDR_WIDTH-1], big-endian: word at A = {Mem[A],Mem[A+1],Mem[A+2],Mem[A+3]}. Reset does not clear Mem.
- Reset (sampled at Clk edge): state IDLE, MOC=0, DataOut=0, Fault=0, latency counter=0. Reset mid-transaction aborts it; no Mem write occurs unless the completing edge already passed.
- FSM states IDLE, BUSY, DONE:
  - IDLE: on edge with MOV=1, latch Address, ReadWrite, DataIn, DataType, Signed; counter<=LATENCY; go BUSY.
  - BUSY: if MOV=0 at an edge, abort to IDLE (no write, outputs unchanged). Else if counter!=0, decrement. Else perform access, set MOC=1, go DONE.
  - DONE: hold MOC, DataOut, Fault while MOV=1. At the first edge with MOV=0, MOC<=0, Fault<=0, go IDLE. DataOut holds its last value.
- Latency: MOC rises LATENCY+1 edges after the edge that sampled MOV high. Minimum gap between requests is 1 IDLE cycle after MOC falls.
- Access at completion edge:
  - Legality: fault if DataType=11, if halfword with Address[0]!=0, or if word with Address[1:0]!=0.
  - Fault case: Fault<=1, DataOut<=0, no write.
  - Read byte: DataOut = {24 x ext, Mem[A]}; halfword: {16 x ext, Mem[A],Mem[A+1]}; ext = Signed ? MSB of loaded data : 0; word: full 32 bits, Signed ignored.
  - Write byte: Mem[A]<=DataIn[7:0]; halfword: Mem[A]<=DataIn[15:8], Mem[A+1]<=DataIn[7:0]; word: all four bytes big-endian. DataOut<=0 on writes.
- Wrap-around: aligned accesses never cross the top of Mem. Address arithmetic is ADDR_WIDTH-bit modulo.
- Inputs other than MOV are ignored outside IDLE (latched copy used).

Test Plan:
- Preload Mem[0..3]=8'h12,8'h34,8'h56,8'h78; LATENCY=2; word read A=0 -> MOC high 3 edges after MOV sampled, DataOut=32'h12345678, Fault=0; drop MOV -> MOC=0 next edge.
- Byte read A=2 with Signed=0 -> 32'h00000056. Preload Mem[4]=8'hF0, Signed=1 byte read A=4 -> 32'hFFFFFFF0. Halfword read A=2, Signed=0 -> 32'h00005678.
- Halfword write A=6 DataIn=32'hAAAABEEF, then word read A=4 -> 32'hF0??BEEF with byte 5 unchanged and bytes 6/7 = BE/EF.
- Word read A=1 -> MOC=1, Fault=1, DataOut=0. DataType=11 write A=8 -> Fault=1, Mem[8..11] unchanged on re-read.
- MOV dropped in BUSY during a word write to A=12 -> no MOC, Mem[12..15] unchanged. Reset asserted in DONE -> MOC=0, DataOut=0 next edge.
- LATENCY=0 instance: word read -> MOC on the edge after acceptance. Back-to-back read, write, read sequence is each acknowledged correctly.
